// File: rtl/carry_lookahead_adder.sv
// Unsigned WIDTH-bit two-level carry-lookahead adder with a zero-latency sum and a registered copy.
// Partial last group is zero-padded (g=0, p=0); o_result_q lags o_result by one i_clk edge.
module carry_lookahead_adder #(
  parameter int WIDTH = 3,
  parameter int GROUP = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result,
  output logic [WIDTH:0]   o_result_q
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;
  localparam int PW = NG * GROUP;

  logic [PW-1:0] g;
  logic [PW-1:0] p;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG-1:0] gc;
  logic [WIDTH:0] c;
  logic [WIDTH:0] result_d;
  logic [WIDTH:0] result_q;

  // Flattened carry into position j of a group: sum of products, no ripple chain.
  function automatic logic grp_carry(input logic [GROUP-1:0] gs, input logic [GROUP-1:0] ps,
                                     input int j, input logic cin);
    logic cy;
    logic t;
    cy = 1'b0;
    for (int k = 0; k < GROUP; k++) begin
      if (k < j) begin
        t = gs[k];
        for (int m = k + 1; m < GROUP; m++) begin
          if (m < j) t = t & ps[m];
        end
        cy = cy | t;
      end
    end
    t = cin;
    for (int m = 0; m < GROUP; m++) begin
      if (m < j) t = t & ps[m];
    end
    return cy | t;
  endfunction

  function automatic logic lvl2_carry(input logic [NG-1:0] ggs, input logic [NG-1:0] gps,
                                      input int j, input logic cin);
    logic cy;
    logic t;
    cy = 1'b0;
    for (int k = 0; k < NG; k++) begin
      if (k < j) begin
        t = ggs[k];
        for (int m = k + 1; m < NG; m++) begin
          if (m < j) t = t & gps[m];
        end
        cy = cy | t;
      end
    end
    t = cin;
    for (int m = 0; m < NG; m++) begin
      if (m < j) t = t & gps[m];
    end
    return cy | t;
  endfunction

  always_comb begin
    g = '0;
    p = '0;
    g[WIDTH-1:0] = i_add1 & i_add2;
    p[WIDTH-1:0] = i_add1 ^ i_add2;
  end

  always_comb begin
    gg = '0;
    gp = '0;
    for (int n = 0; n < NG; n++) begin
      gg[n] = grp_carry(g[n*GROUP +: GROUP], p[n*GROUP +: GROUP], GROUP, 1'b0);
      gp[n] = &p[n*GROUP +: GROUP];
    end
  end

  always_comb begin
    gc = '0;
    for (int n = 0; n < NG; n++) begin
      gc[n] = lvl2_carry(gg, gp, n, 1'b0);
    end
  end

  // Carry-out on a group boundary comes straight from the second level.
  always_comb begin
    c = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      int n;
      n = (i / GROUP < NG) ? (i / GROUP) : (NG - 1);
      if (i == PW) begin
        c[i] = lvl2_carry(gg, gp, NG, 1'b0);
      end else begin
        c[i] = grp_carry(g[n*GROUP +: GROUP], p[n*GROUP +: GROUP], i - n * GROUP, gc[n]);
      end
    end
  end

  assign o_result = {c[WIDTH], p[WIDTH-1:0] ^ c[WIDTH-1:0]};
  assign result_d = o_result;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign o_result_q = result_q;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Bench for carry_lookahead_adder at WIDTH 3, 6 (partial group) and 8.
module tb_carry_lookahead_adder;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic [5:0] a6 = '0, b6 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] r3, q3;
  logic [6:0] r6, q6;
  logic [8:0] r8, q8;
  logic       cmp_on = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         mq3 = 0;
  int         mq6 = 0;
  int         mq8 = 0;
  logic [7:0] t8a [6] = '{8'd255, 8'd170, 8'd255, 8'd0, 8'd128, 8'd1};
  logic [7:0] t8b [6] = '{8'd1,   8'd85,  8'd255, 8'd0, 8'd128, 8'd254};

  carry_lookahead_adder #(.WIDTH(3), .GROUP(4)) u_w3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_add1(a3), .i_add2(b3), .o_result(r3), .o_result_q(q3));
  carry_lookahead_adder #(.WIDTH(6), .GROUP(4)) u_w6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_add1(a6), .i_add2(b6), .o_result(r6), .o_result_q(q6));
  carry_lookahead_adder #(.WIDTH(8), .GROUP(4)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_add1(a8), .i_add2(b8), .o_result(r8), .o_result_q(q8));

  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition; the register simply remembers the last sum seen at a live edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq3 = 0; mq6 = 0; mq8 = 0;
      end else begin
        mq3 = int'(a3) + int'(b3);
        mq6 = int'(a6) + int'(b6);
        mq8 = int'(a8) + int'(b8);
      end
      #1;
      if (cmp_on) begin
        chk("sum_w3", 64'(r3), 64'(int'(a3) + int'(b3)));
        chk("sum_w6", 64'(r6), 64'(int'(a6) + int'(b6)));
        chk("sum_w8", 64'(r8), 64'(int'(a8) + int'(b8)));
        chk("reg_w3", 64'(q3), 64'(mq3));
        chk("reg_w6", 64'(q6), 64'(mq6));
        chk("reg_w8", 64'(q8), 64'(mq8));
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    chk("reset_q3", 64'(q3), 64'd0);
    chk("reset_q8", 64'(q8), 64'd0);
    chk("reset_sum_0p0", 64'(r3), 64'd0);
    cmp_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int idx = 0; idx < 4096; idx++) begin
      @(negedge clk);
      a6 = idx[11:6];
      b6 = idx[5:0];
      a3 = idx[5:3];
      b3 = idx[2:0];
      a8 = t8a[idx % 6];
      b8 = t8b[idx % 6];
    end

    @(negedge clk);
    a3 = 3'd3; b3 = 3'd4; #1;
    chk("comb_3p4", 64'(r3), 64'd7);
    chk("hold_before_edge", 64'(q3), 64'd14);
    @(posedge clk); #1;
    chk("reg_3p4", 64'(q3), 64'd7);

    @(negedge clk);
    a8 = 8'd255; b8 = 8'd1; #1;
    chk("w8_255p1", 64'(r8), 64'd256);
    a8 = 8'd170; b8 = 8'd85; #1;
    chk("w8_170p85", 64'(r8), 64'd255);
    a8 = 8'd255; b8 = 8'd255; #1;
    chk("w8_255p255", 64'(r8), 64'd510);
    a3 = 3'd5; b3 = 3'd3; a6 = 6'd63; b6 = 6'd1; #1;
    chk("w3_5p3", 64'(r3), 64'd8);
    chk("w6_63p1", 64'(r6), 64'd64);

    @(negedge clk);
    a3 = 3'd7; b3 = 3'd7;
    @(posedge clk); #1;
    chk("w3_7p7_q", 64'(q3), 64'd14);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_q", 64'(q3), 64'd0);
    chk("reset_keeps_sum", 64'(r3), 64'd14);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("q_zero_until_edge", 64'(q3), 64'd0);
    @(posedge clk); #1;
    chk("q_after_release", 64'(q3), 64'd14);

    @(negedge clk);
    clk_en = 1'b0;
    a3 = 3'd2; b3 = 3'd1; a6 = 6'd63; b6 = 6'd63;
    #20;
    chk("stopped_sum_2p1", 64'(r3), 64'd3);
    chk("stopped_w6_max", 64'(r6), 64'd126);
    chk("stopped_hold", 64'(q3), 64'd14);
    a3 = 3'd6; b3 = 3'd5;
    #20;
    chk("stopped_sum_6p5", 64'(r3), 64'd11);
    chk("stopped_hold2", 64'(q3), 64'd14);
    clk_en = 1'b1;
    @(posedge clk); #1;
    chk("resume_capture", 64'(q3), 64'd11);
    chk("resume_w6", 64'(q6), 64'd126);

    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
